dac_channel_scheduler: RTL and testbench
========================================

Name: dac_channel_scheduler

Overview:
Shares the single SPI DAC driver (LTC2624, four 12-bit channels) between four per-channel requesters and one broadcast requester. It arbitrates the requesters and latches the winner's value. It then drives the driver's data/address/command/dactrig interface and waits for dacdone before granting again. It sits between the user-control logic (buttons/switches, waveform sources) and the SPI DAC driver.

Parameters:
NCH, 4, number of channel requesters (fixed to 4 for LTC2624)
DW, 12, DAC sample width
CMD_WRUPD, 4'b0011, command nibble "write and update channel"
ADDR_ALL, 4'b1111, broadcast address
TIMEOUT, 4096, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1)

Ports:
CLK50MHZ  in  1  system clock, 50 MHz
RST  in  1  reset, asynchronous, active-low (0 = reset)
req  in  NCH  level request per channel; held until matching ack
req_data  in  NCH*DW  packed values; channel i at [DW*i+DW-1 : DW*i]
bcast_req  in  1  level request: write same value to all channels
bcast_data  in  DW  broadcast value
ack  out  NCH  one-cycle pulse: channel i value latched, req may drop/change
bcast_ack  out  1  one-cycle pulse for broadcast
data  out  DW  value to driver
address  out  4  channel address to driver (ch i -> 4'(i); broadcast -> ADDR_ALL)
command  out  4  command to driver
dactrig  out  1  one-cycle start pulse to driver
dacdone  in  1  one-cycle pulse from driver: transfer finished
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky: a transfer exceeded TIMEOUT
last_addr  out  4  address of last completed transfer (debug/LED)

Behaviour:
- Reset (RST=0, async): state=IDLE, data=0, address=0, command=CMD_WRUPD, dactrig=0, ack=0, bcast_ack=0, busy=0, err_timeout=0, last_addr=0, rr_ptr=0, timeout counter=0.
- All outputs are registered. No combinational path exists from inputs to outputs.
- FSM states: IDLE, TRIG, WAIT.
- IDLE, transitions on a clock edge with any request active:
  - Broadcast has priority: if bcast_req, then data=bcast_data, address=ADDR_ALL, bcast_ack pulses.
  - Otherwise a round-robin search runs over req starting at rr_ptr. The first set bit i wins: data=req_data[i], address=i, ack[i] pulses.
  - command=CMD_WRUPD in both cases; next state TRIG.
  - With no request, IDLE holds and all outputs hold their values.
- TRIG: dactrig=1 for exactly this one cycle; timeout counter=0; next state WAIT.
- WAIT:
  - On dacdone: go to IDLE, last_addr=address. If the winner was channel i, rr_ptr=(i+1) mod NCH. A broadcast leaves rr_ptr unchanged.
  - With no dacdone, the counter increments. When it reaches TIMEOUT: err_timeout=1 (sticky until reset), go to IDLE, rr_ptr advances as on dacdone.
- Latency: request sampled at edge n gives ack at n+1 and dactrig at n+2. The earliest next grant is the edge after dacdone is sampled in WAIT.
- data/address/command stay stable from the grant edge until the next grant. The driver may sample them at any time during the transfer.
- dacdone outside WAIT (IDLE or TRIG) is ignored. A dacdone coincident with the timeout terminal count counts as completion; err_timeout is not set.
- A requester that keeps req asserted after ack is treated as a new request with its current req_data. Round robin guarantees the other channels are served between its repeats.
- Simultaneous bcast_req and channel reqs: broadcast wins every time. Starvation of channels under a continuous bcast_req is accepted and documented.
- Reset mid-transfer: the FSM returns to IDLE immediately and dactrig drops. A dacdone from the aborted driver transfer arrives in IDLE and is ignored.

Decomposition:
- Shared package dac_pkg: LTC2624 command constants (CMD_WRUPD, ADDR_ALL, channel addresses) and the FSM state enum.
- One sub-module, rr_arbiter: NCH-wide round-robin priority pick. Inputs are the req vector and rr_ptr; outputs are a one-hot grant and the grant index. It is purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Reset release, req=4'b0100, req_data ch2=12'hABC -> ack=4'b0100 one cycle later; dactrig pulses next cycle; data=12'hABC, address=4'h2, command=4'h3; busy high until dacdone.
- req=4'b1111 held, dacdone returned 20 cycles after each dactrig -> grant order ch0,ch1,ch2,ch3,ch0; exactly one dactrig per dacdone.
- bcast_req with bcast_data=12'hFFF while req=4'b0011 -> bcast_ack first, address=4'hF, data=12'hFFF; then ch0, then ch1.
- dacdone never returned, TIMEOUT=16 -> err_timeout=1 sixteen cycles after entering WAIT; FSM in IDLE; next request (ch1) still serviced normally.
- RST pulsed low during WAIT, then a stray dacdone in IDLE -> all outputs at reset values; no dactrig and no ack generated.
- dacdone asserted during TRIG (spurious) -> ignored; FSM still waits for a dacdone in WAIT before granting again.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and types for the LTC2624 channel scheduler.
//   CMD_WRUPD  - command nibble "write and update channel n"
//   ADDR_ALL   - broadcast address (all four DAC channels)
//   ADDR_CH*   - per-channel addresses
//   sched_state_e - scheduler FSM states
package dac_pkg;

    localparam logic [3:0] CMD_WRUPD = 4'b0011;
    localparam logic [3:0] ADDR_ALL  = 4'b1111;
    localparam logic [3:0] ADDR_CH0  = 4'h0;
    localparam logic [3:0] ADDR_CH1  = 4'h1;
    localparam logic [3:0] ADDR_CH2  = 4'h2;
    localparam logic [3:0] ADDR_CH3  = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dac_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NCH requesters.
//   req     - request vector
//   ptr     - highest-priority index for this pick
//   gnt     - one-hot grant (all zero when req is zero)
//   gnt_idx - index of the granted requester (0 when nothing granted)
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx
);

    logic found;
    int   idx;

    // Walk the requesters starting at ptr; the first set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler: shares one LTC2624 SPI driver between NCH channel
// requesters and a broadcast requester.
//   CLK50MHZ, RST            - clock, async active-low reset
//   req/req_data             - per-channel level requests and values
//   bcast_req/bcast_data     - broadcast request (always wins) and value
//   ack/bcast_ack            - one-cycle grant pulses
//   data/address/command     - held to the driver from grant to next grant
//   dactrig/dacdone          - driver start pulse / completion pulse
//   busy                     - scheduler not idle
//   err_timeout              - sticky: a transfer never completed
//   last_addr                - address of the last completed transfer
module dac_channel_scheduler
    import dac_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] req_data,
    input  logic              bcast_req,
    input  logic [DW-1:0]     bcast_data,
    output logic [NCH-1:0]    ack,
    output logic              bcast_ack,
    output logic [DW-1:0]     data,
    output logic [3:0]        address,
    output logic [3:0]        command,
    output logic              dactrig,
    input  logic              dacdone,
    output logic              busy,
    output logic              err_timeout,
    output logic [3:0]        last_addr
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_e     state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [3:0]       address_q, address_d;
    logic [3:0]       command_q, command_d;
    logic             dactrig_q, dactrig_d;
    logic [NCH-1:0]   ack_q, ack_d;
    logic             bcast_ack_q, bcast_ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [3:0]       last_addr_q, last_addr_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    win_idx_q, win_idx_d;
    logic             win_bcast_q, win_bcast_d;

    logic [NCH-1:0]   gnt;
    logic [IW-1:0]    gnt_idx;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        address_d   = address_q;
        command_d   = command_q;
        dactrig_d   = 1'b0;
        ack_d       = '0;
        bcast_ack_d = 1'b0;
        err_d       = err_q;
        last_addr_d = last_addr_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        win_idx_d   = win_idx_q;
        win_bcast_d = win_bcast_q;

        case (state_q)
            ST_IDLE: begin
                if (bcast_req) begin
                    data_d      = bcast_data;
                    address_d   = ADDR_ALL;
                    command_d   = CMD_WRUPD;
                    bcast_ack_d = 1'b1;
                    win_bcast_d = 1'b1;
                    state_d     = ST_TRIG;
                end else if (|req) begin
                    data_d      = req_data[gnt_idx*DW +: DW];
                    address_d   = 4'(gnt_idx);
                    command_d   = CMD_WRUPD;
                    ack_d       = gnt;
                    win_idx_d   = gnt_idx;
                    win_bcast_d = 1'b0;
                    state_d     = ST_TRIG;
                end
            end
            ST_TRIG: begin
                // Registered, so the pulse is seen during the first WAIT cycle.
                dactrig_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // dacdone on the terminal count is a completion, not a timeout.
                if (dacdone || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    if (dacdone) last_addr_d = address_q;
                    else         err_d       = 1'b1;
                    if (!win_bcast_q)
                        rr_ptr_d = (win_idx_q == IW'(NCH - 1)) ? '0 : win_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            address_q   <= '0;
            command_q   <= CMD_WRUPD;
            dactrig_q   <= 1'b0;
            ack_q       <= '0;
            bcast_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            win_idx_q   <= '0;
            win_bcast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            address_q   <= address_d;
            command_q   <= command_d;
            dactrig_q   <= dactrig_d;
            ack_q       <= ack_d;
            bcast_ack_q <= bcast_ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            win_idx_q   <= win_idx_d;
            win_bcast_q <= win_bcast_d;
        end
    end

    assign data        = data_q;
    assign address     = address_q;
    assign command     = command_q;
    assign dactrig     = dactrig_q;
    assign ack         = ack_q;
    assign bcast_ack   = bcast_ack_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign last_addr   = last_addr_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Scoreboard bench for dac_channel_scheduler: a cycle-level reference model
// pushes expected grants, a negedge monitor compares DUT outputs.
module tb_dac_channel_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*DW-1:0] req_data = '0;
    logic              bcast_req = 1'b0;
    logic [DW-1:0]     bcast_data = '0;
    logic [NCH-1:0]    ack;
    logic              bcast_ack;
    logic [DW-1:0]     data;
    logic [3:0]        address;
    logic [3:0]        command;
    logic              dactrig;
    logic              dacdone;
    logic              busy;
    logic              err_timeout;
    logic [3:0]        last_addr;

    logic drv_done = 1'b0;
    logic man_done = 1'b0;
    assign dacdone = drv_done | man_done;

    always #10 clk = ~clk;

    dac_channel_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(TO)) dut (
        .CLK50MHZ(clk), .RST(rst_n), .req(req), .req_data(req_data),
        .bcast_req(bcast_req), .bcast_data(bcast_data), .ack(ack),
        .bcast_ack(bcast_ack), .data(data), .address(address),
        .command(command), .dactrig(dactrig), .dacdone(dacdone),
        .busy(busy), .err_timeout(err_timeout), .last_addr(last_addr)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [3:0] ackv; logic bc; logic [11:0] dat; logic [3:0] adr; } exp_t;
    exp_t expq[$];

    bit         m_busy, m_err, m_grant_now, m_bc;
    int         m_age, m_ptr, m_win;
    logic [11:0] m_data;
    logic [3:0] m_addr, m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_grant_now = 0; m_bc = 0;
            m_age = 0; m_ptr = 0; m_win = 0;
            m_data = '0; m_addr = '0; m_last = '0;
        end else begin
            m_grant_now = 0;
            if (m_busy) begin
                // age counts edges since the grant: 1 = trigger edge, >=2 waiting.
                m_age++;
                if ((m_age >= 2 && dacdone) || m_age == TO + 1) begin
                    if (m_age >= 2 && dacdone) m_last = m_addr;
                    else                       m_err  = 1;
                    if (!m_bc) m_ptr = (m_win + 1) % NCH;
                    m_busy = 0;
                end
            end else if (bcast_req || req != 0) begin
                exp_t e;
                if (bcast_req) begin
                    m_bc = 1;
                    e = '{ackv: 4'b0, bc: 1'b1, dat: bcast_data, adr: 4'hF};
                end else begin
                    bit found;
                    found = 0;
                    for (int k = 0; k < NCH; k++) begin
                        int c;
                        c = (m_ptr + k) % NCH;
                        if (!found && req[c]) begin found = 1; m_win = c; end
                    end
                    m_bc = 0;
                    e = '{ackv: 4'(1 << m_win), bc: 1'b0,
                          dat: req_data[m_win*DW +: DW], adr: 4'(m_win)};
                end
                m_data = e.dat; m_addr = e.adr;
                expq.push_back(e);
                m_busy = 1; m_age = 0; m_grant_now = 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int rd_idx = 0;
    int glog[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("dactrig", 32'(dactrig), 32'(m_busy && m_age == 1));
            chk("err_timeout", 32'(err_timeout), 32'(m_err));
            chk("last_addr", 32'(last_addr), 32'(m_last));
            chk("data_hold", 32'(data), 32'(m_data));
            chk("address_hold", 32'(address), 32'(m_addr));
            chk("command", 32'(command), 32'h3);
            chk("grant_pulse", 32'((ack != 0) || bcast_ack), 32'(m_grant_now));
            if (ack != 0 || bcast_ack) begin
                if (rd_idx >= expq.size()) begin
                    checks++; failures++;
                    $display("FAIL grant_unexpected actual ack=%b bcast_ack=%b required none", ack, bcast_ack);
                end else begin
                    chk("ack_vec", 32'(ack), 32'(expq[rd_idx].ackv));
                    chk("bcast_ack", 32'(bcast_ack), 32'(expq[rd_idx].bc));
                    chk("grant_data", 32'(data), 32'(expq[rd_idx].dat));
                    chk("grant_addr", 32'(address), 32'(expq[rd_idx].adr));
                    rd_idx++;
                end
                glog.push_back(int'(address));
            end
        end
    end

    // ---------------- DAC driver model ----------------
    bit drv_silent = 0;
    bit drv_rand = 0;
    int drv_delay = 10;
    int drv_d;

    always begin
        @(posedge clk); #2;
        if (dactrig && !drv_silent) begin
            drv_d = drv_rand ? int'($urandom_range(1, 18)) : drv_delay;
            repeat (drv_d) @(posedge clk);
            #2 drv_done = 1'b1;
            @(posedge clk); #2 drv_done = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, 32'(data), 32'h0);
        chk({tag, "_address"}, 32'(address), 32'h0);
        chk({tag, "_command"}, 32'(command), 32'h3);
        chk({tag, "_dactrig"}, 32'(dactrig), 32'h0);
        chk({tag, "_ack"}, 32'({ack, bcast_ack}), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(err_timeout), 32'h0);
        chk({tag, "_last_addr"}, 32'(last_addr), 32'h0);
    endtask

    // Drops each request once acked; ends when nothing is pending or busy.
    task automatic serve(input string tag);
        int n;
        n = 0;
        while ((req != 0 || bcast_req || busy) && n < 400) begin
            step(); n++;
            for (int i = 0; i < NCH; i++) if (ack[i]) req[i] = 1'b0;
            if (bcast_ack) bcast_req = 1'b0;
        end
        if (n >= 400) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=still_busy required=idle", tag);
        end
    endtask

    task automatic set_ch(input int i, input logic [11:0] v);
        req_data[i*DW +: DW] = v;
        req[i] = 1'b1;
    endtask

    initial begin
        int base, n, cnt;
        logic [11:0] v;

        // Reset state
        rst_n = 1'b0;
        step(); step();
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Single channel grant
        set_ch(2, 12'hABC);
        serve("single");
        chk("single_last_addr", 32'(last_addr), 32'h2);

        // Four channels held: round robin from ch0
        do_reset();
        base = glog.size();
        for (int i = 0; i < NCH; i++) set_ch(i, 12'(12'h100 * (i + 1)));
        cnt = 0; n = 0;
        while (cnt < 5 && n < 400) begin
            step(); n++;
            if (ack != 0) cnt++;
        end
        req = '0;
        serve("rr_drain");
        chk("rr_count", 32'(glog.size() - base), 32'd5);
        for (int k = 0; k < 5; k++)
            if (base + k < glog.size()) chk("rr_order", 32'(glog[base + k]), 32'(k % NCH));

        // Broadcast beats channel requests
        do_reset();
        base = glog.size();
        bcast_data = 12'hFFF; bcast_req = 1'b1;
        set_ch(0, 12'h011); set_ch(1, 12'h022);
        serve("bcast");
        chk("bcast_count", 32'(glog.size() - base), 32'd3);
        if (glog.size() >= base + 3) begin
            chk("bcast_first", 32'(glog[base]), 32'hF);
            chk("bcast_then0", 32'(glog[base + 1]), 32'h0);
            chk("bcast_then1", 32'(glog[base + 2]), 32'h1);
        end

        // Timeout, then normal service
        drv_silent = 1;
        set_ch(2, 12'h555);
        serve("timeout");
        chk("timeout_err", 32'(err_timeout), 32'h1);
        chk("timeout_idle", 32'(busy), 32'h0);
        drv_silent = 0;
        set_ch(1, 12'h123);
        serve("after_timeout");
        chk("after_timeout_last", 32'(last_addr), 32'h1);
        chk("after_timeout_err", 32'(err_timeout), 32'h1);

        // Spurious dacdone during TRIG is ignored
        drv_silent = 1;
        set_ch(3, 12'h333);
        n = 0;
        while (!ack[3] && n < 50) begin step(); n++; end
        chk("spur_ack_seen", 32'(ack[3]), 32'h1);
        req[3] = 1'b0;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        set_ch(0, 12'h0AA);
        repeat (6) step();
        chk("spur_still_busy", 32'(busy), 32'h1);
        chk("spur_no_grant", 32'({ack, bcast_ack}), 32'h0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        drv_silent = 0;
        serve("spur");
        chk("spur_last", 32'(last_addr), 32'h0);

        // Reset during WAIT, stray dacdone afterwards
        drv_delay = 8;
        set_ch(0, 12'h777);
        n = 0;
        while (!ack[0] && n < 50) begin step(); n++; end
        req[0] = 1'b0;
        repeat (4) step();
        chk("midrst_busy_before", 32'(busy), 32'h1);
        do_reset();
        chk_reset_vals("midrst");
        repeat (8) step();
        chk_reset_vals("stray_done");
        drv_delay = 10;

        // Randomized traffic
        drv_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                v = 12'($urandom);
                if (ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_data[i*DW +: DW] = v;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_ch(i, v);
                end
            end
            if (bcast_ack) bcast_req = 1'b0;
            else if (!bcast_req && $urandom_range(0, 15) == 0) begin
                bcast_data = 12'($urandom);
                bcast_req = 1'b1;
            end
        end
        req = '0; bcast_req = 1'b0;
        serve("random_drain");
        repeat (25) step();
        chk("scoreboard_drained", 32'(expq.size() - rd_idx), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
